// File: rtl/instruction_sequencer_pkg.sv
// Shared opcode values, instruction field positions and sequencer state encodings.
// Used by the ROM sequencer and by anything that builds or decodes its instructions.
package instruction_sequencer_pkg;

    localparam int INSTR_W = 28;
    localparam int ADDR_W  = 8;

    localparam int OP_MSB = 27;
    localparam int OP_LSB = 24;
    localparam int A_MSB  = 23;
    localparam int A_LSB  = 16;
    localparam int B_MSB  = 15;
    localparam int B_LSB  = 8;
    localparam int C_MSB  = 7;
    localparam int C_LSB  = 0;

    typedef logic [OP_MSB-OP_LSB:0] opcode_t;

    localparam opcode_t OP_NOP  = 4'h0;
    localparam opcode_t OP_JMP  = 4'h1;
    localparam opcode_t OP_BEQ  = 4'h2;
    localparam opcode_t OP_BLE  = 4'h3;
    localparam opcode_t OP_CALL = 4'h4;
    localparam opcode_t OP_RET  = 4'h5;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } seq_state_e;

endpackage

// File: rtl/return_stack.sv
// Return-address LIFO: push writes mem[count], pop reads mem[count-1]; single cycle.
// Push while full and pop while empty are ignored; the caller decides what that means.
module return_stack #(
    parameter int DEPTH = 8,
    parameter int W     = 8,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  push_dat_i,
    output logic          full_o,
    output logic          empty_o,
    output logic [W-1:0]  top_o,
    output logic [CW-1:0] count_o
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] top_cnt;
    logic [AW-1:0] wr_idx, top_idx;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign wr_idx  = count_q[AW-1:0];
    assign top_cnt = count_q - ONE;
    assign top_idx = top_cnt[AW-1:0];
    assign top_o   = empty_o ? '0 : mem_q[top_idx];

    always_comb begin
        count_d = count_q;
        if (push_i && !full_o) begin
            count_d = count_q + ONE;
        end else if (pop_i && !empty_o) begin
            count_d = count_q - ONE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Contents are only visible through count, so they need no reset.
    always_ff @(posedge clk_i) begin
        if (push_i && !full_o) begin
            mem_q[wr_idx] <= push_dat_i;
        end
    end

endmodule

// File: rtl/instruction_sequencer.sv
// PC, call stack and next-address mux in front of the instruction ROM; one instruction per cycle.
// iStall freezes everything; stack overflow/underflow locks into FAULT until Reset.
module instruction_sequencer
    import instruction_sequencer_pkg::*;
#(
    parameter int              STACK_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_ADDR = 8'd0,
    localparam int             CW          = $clog2(STACK_DEPTH) + 1
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [INSTR_W-1:0] iInstruction,
    input  logic               iBranchTaken,
    input  logic               iStall,
    output logic [ADDR_W-1:0]  oAddress,
    output logic [ADDR_W-1:0]  oReturnTop,
    output logic [CW-1:0]      oStackCount,
    output logic               oFault
);

    seq_state_e        state_q;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              fault_q;
    logic              go_fault;
    logic              push, pop;
    logic              stk_full, stk_empty;
    logic [ADDR_W-1:0] pc_plus1;
    opcode_t           op;
    logic [ADDR_W-1:0] fld_a, fld_b;
    logic              unused_c;

    assign op       = iInstruction[OP_MSB:OP_LSB];
    assign fld_a    = iInstruction[A_MSB:A_LSB];
    assign fld_b    = iInstruction[B_MSB:B_LSB];
    assign unused_c = ^iInstruction[C_MSB:C_LSB];
    assign pc_plus1 = pc_q + 8'd1;

    always_comb begin
        pc_d     = pc_q;
        push     = 1'b0;
        pop      = 1'b0;
        go_fault = 1'b0;
        if (state_q == ST_RUN && !iStall) begin
            case (op)
                OP_JMP: pc_d = fld_a;
                OP_BEQ,
                OP_BLE: pc_d = iBranchTaken ? fld_a : pc_plus1;
                OP_CALL: begin
                    if (stk_full) begin
                        go_fault = 1'b1;
                    end else begin
                        push = 1'b1;
                        pc_d = fld_b;
                    end
                end
                OP_RET: begin
                    if (stk_empty) begin
                        go_fault = 1'b1;
                    end else begin
                        pop  = 1'b1;
                        pc_d = oReturnTop;
                    end
                end
                default: pc_d = pc_plus1;
            endcase
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_ADDR;
            fault_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (go_fault) begin
                        state_q <= ST_FAULT;
                        fault_q <= 1'b1;
                    end else begin
                        pc_q <= pc_d;
                    end
                end
                default: begin
                    state_q <= ST_FAULT;
                    fault_q <= 1'b1;
                end
            endcase
        end
    end

    return_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (ADDR_W)
    ) u_stack (
        .clk_i      (Clock),
        .rst_i      (Reset),
        .push_i     (push),
        .pop_i      (pop),
        .push_dat_i (pc_plus1),
        .full_o     (stk_full),
        .empty_o    (stk_empty),
        .top_o      (oReturnTop),
        .count_o    (oStackCount)
    );

    assign oAddress = pc_q;
    assign oFault   = fault_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Bench for instruction_sequencer: ROM model driven from oAddress, queue-based reference model.
module tb_instruction_sequencer;
    import instruction_sequencer_pkg::*;

    localparam int DEPTH = 8;

    logic        Clock;
    logic        Reset;
    logic [27:0] iInstruction;
    logic        iBranchTaken;
    logic        iStall;
    logic [7:0]  oAddress;
    logic [7:0]  oReturnTop;
    logic [3:0]  oStackCount;
    logic        oFault;

    logic [27:0] rom [256];

    logic [7:0]  m_pc;
    logic [7:0]  stk [$];
    logic        m_fault;

    int n_checks = 0;
    int n_pass   = 0;

    instruction_sequencer #(
        .STACK_DEPTH (DEPTH),
        .RESET_ADDR  (8'd0)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .iInstruction (iInstruction),
        .iBranchTaken (iBranchTaken),
        .iStall       (iStall),
        .oAddress     (oAddress),
        .oReturnTop   (oReturnTop),
        .oStackCount  (oStackCount),
        .oFault       (oFault)
    );

    assign iInstruction = rom[oAddress];

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic [27:0] mk(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        return {op, a, b, 8'h00};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic rom_clear();
        for (int i = 0; i < 256; i++) rom[i] = mk(OP_NOP, 8'h00, 8'h00);
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, "_addr"},  32'(oAddress),    32'(m_pc));
        chk({tag, "_count"}, 32'(oStackCount), 32'(stk.size()));
        chk({tag, "_top"},   32'(oReturnTop),  (stk.size() == 0) ? 32'd0 : 32'(stk[stk.size()-1]));
        chk({tag, "_fault"}, 32'(oFault),      32'(m_fault));
    endtask

    // Architectural effect of one fetched instruction.
    task automatic model_step(input logic st, input logic bt);
        logic [27:0] ins;
        logic [3:0]  op;
        ins = rom[m_pc];
        op  = ins[27:24];
        if (m_fault || st) return;
        if (op == OP_JMP) begin
            m_pc = ins[23:16];
        end else if (op == OP_BEQ || op == OP_BLE) begin
            m_pc = bt ? ins[23:16] : m_pc + 8'd1;
        end else if (op == OP_CALL) begin
            if (stk.size() == DEPTH) m_fault = 1'b1;
            else begin
                stk.push_back(m_pc + 8'd1);
                m_pc = ins[15:8];
            end
        end else if (op == OP_RET) begin
            if (stk.size() == 0) m_fault = 1'b1;
            else m_pc = stk.pop_back();
        end else begin
            m_pc = m_pc + 8'd1;
        end
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic cycle(input logic st, input logic bt);
        iStall       = st;
        iBranchTaken = bt;
        @(posedge Clock);
        model_step(st, bt);
        #1;
        cmp_model("cyc");
        @(negedge Clock);
    endtask

    // Reset pulse lands between edges so the clear is seen asynchronously.
    task automatic do_reset();
        Reset = 1'b1;
        #2;
        m_pc    = 8'd0;
        m_fault = 1'b0;
        stk.delete();
        cmp_model("rst");
        #1;
        Reset = 1'b0;
    endtask

    initial begin
        Reset        = 1'b1;
        iStall       = 1'b0;
        iBranchTaken = 1'b0;
        m_pc         = 8'd0;
        m_fault      = 1'b0;

        // Three calls to the sleep routine at 100, then the branch at 10.
        rom_clear();
        rom[0]   = mk(OP_CALL, 8'h00, 8'd100);
        rom[1]   = mk(OP_CALL, 8'h00, 8'd100);
        rom[2]   = mk(OP_CALL, 8'h00, 8'd100);
        rom[3]   = mk(OP_JMP,  8'd10, 8'h00);
        rom[10]  = mk(OP_BEQ,  8'd15, 8'h00);
        rom[11]  = mk(OP_JMP,  8'd10, 8'h00);
        rom[15]  = mk(OP_JMP,  8'd10, 8'h00);
        rom[117] = mk(OP_RET,  8'h00, 8'h00);
        @(negedge Clock);
        do_reset();
        chk("reset_addr", 32'(oAddress), 32'd0);
        cycle(1'b0, 1'b1);
        chk("call0_addr", 32'(oAddress), 32'd100);
        chk("call0_count", 32'(oStackCount), 32'd1);
        chk("call0_top", 32'(oReturnTop), 32'd1);
        for (int i = 0; i < 17; i++) cycle(1'b0, 1'($urandom));
        chk("at_ret", 32'(oAddress), 32'd117);
        cycle(1'b0, 1'b0);
        chk("ret_addr", 32'(oAddress), 32'd1);
        chk("ret_count", 32'(oStackCount), 32'd0);
        for (int i = 0; i < 38; i++) cycle(1'b0, 1'b0);
        chk("after_calls", 32'(oAddress), 32'd3);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);
        chk("beq_taken", 32'(oAddress), 32'd15);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        chk("beq_not_taken", 32'(oAddress), 32'd11);
        for (int i = 0; i < 60; i++) cycle(($urandom_range(0, 3) == 0), 1'($urandom));

        // Nine nested calls overflow an eight-deep stack.
        rom_clear();
        rom[0] = mk(OP_JMP, 8'd20, 8'h00);
        for (int i = 0; i < 9; i++) rom[20+i] = mk(OP_CALL, 8'h00, 8'(21 + i));
        rom[29] = mk(OP_RET, 8'h00, 8'h00);
        do_reset();
        for (int i = 0; i < 9; i++) cycle(1'b0, 1'b0);
        chk("nest8_count", 32'(oStackCount), 32'd8);
        cycle(1'b0, 1'b0);
        chk("ovf_fault", 32'(oFault), 32'd1);
        chk("ovf_addr", 32'(oAddress), 32'd28);
        for (int i = 0; i < 15; i++) cycle(1'($urandom), 1'($urandom));
        chk("ovf_frozen_addr", 32'(oAddress), 32'd28);
        chk("ovf_frozen_top", 32'(oReturnTop), 32'd28);

        // Return with nothing on the stack.
        rom_clear();
        rom[0] = mk(OP_JMP, 8'd7, 8'h00);
        rom[7] = mk(OP_RET, 8'h00, 8'h00);
        do_reset();
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        chk("unf_fault", 32'(oFault), 32'd1);
        chk("unf_addr", 32'(oAddress), 32'd7);

        // Sequential wrap past 255.
        rom_clear();
        rom[0] = mk(OP_JMP, 8'd250, 8'h00);
        do_reset();
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1);
        chk("at_255", 32'(oAddress), 32'd255);
        cycle(1'b0, 1'b1);
        chk("wrap_addr", 32'(oAddress), 32'd0);

        // Stalled CALL, then release.
        rom_clear();
        rom[0]  = mk(OP_CALL, 8'h00, 8'd50);
        rom[50] = mk(OP_RET, 8'h00, 8'h00);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'($urandom));
            chk("stall_addr", 32'(oAddress), 32'd0);
            chk("stall_count", 32'(oStackCount), 32'd0);
        end
        cycle(1'b0, 1'b0);
        chk("unstall_addr", 32'(oAddress), 32'd50);
        chk("unstall_count", 32'(oStackCount), 32'd1);
        cycle(1'b0, 1'b0);
        chk("unstall_ret", 32'(oAddress), 32'd1);

        // Random programs with periodic asynchronous resets.
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < 256; i++) begin
                int sel;
                sel = $urandom_range(0, 15);
                if (sel < 3)       rom[i] = {OP_CALL, 8'($urandom), 8'($urandom), 8'($urandom)};
                else if (sel < 5)  rom[i] = {OP_RET, 24'($urandom)};
                else if (sel < 6)  rom[i] = {OP_JMP, 24'($urandom)};
                else if (sel < 8)  rom[i] = {OP_BEQ, 24'($urandom)};
                else if (sel < 10) rom[i] = {OP_BLE, 24'($urandom)};
                else               rom[i] = {4'($urandom_range(6, 15)), 24'($urandom)};
            end
            do_reset();
            for (int i = 0; i < 40; i++) cycle(($urandom_range(0, 4) == 0), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instruction_sequencer.md
# instruction_sequencer

Program-counter and call-stack stage directly upstream of the 256-entry instruction ROM. Drives the 8-bit fetch address, inspects the 28-bit instruction returned combinationally by the ROM, and computes the next address for sequential flow, `JMP`, `BEQ`/`BLE`, `CALL` and `RET`. Keeps return addresses in a hardware LIFO so subroutines such as the sleep routine at address 100 return correctly.

## Interface
- `STACK_DEPTH`, 8: number of return-address entries; a power of two, at least 2.
- `RESET_ADDR`, 8'd0: fetch address loaded on reset.
- `Clock` in 1: rising-edge clock.
- `Reset` in 1: asynchronous, active-high reset.
- `iInstruction` in 28: ROM output for `oAddress`. Fields: `[27:24]` opcode, `[23:16]` A, `[15:8]` B, `[7:0]` C.
- `iBranchTaken` in 1: compare result from the register file/ALU for the current `BEQ`/`BLE`; valid in the same cycle.
- `iStall` in 1: when 1, hold PC and stack and ignore the current instruction.
- `oAddress` out 8: ROM address, equal to the PC register.
- `oReturnTop` out 8: return address at the top of stack; 0 when empty.
- `oStackCount` out $clog2(STACK_DEPTH)+1: number of valid entries.
- `oFault` out 1: sticky fault flag.

## Operation
- Opcode values come from the shared definitions include; this block never redefines them.
- State machine with two states: `RUN` and `FAULT`. Reset enters `RUN`.
- Next-PC rules in `RUN` with `iStall`=0, where PC+1 wraps 255→0:
  - `JMP`: PC ← A.
  - `BEQ`/`BLE`: PC ← A if `iBranchTaken`, else PC+1.
  - `CALL`: push PC+1, then PC ← B. Field B is the target, matching the existing `{CALL, 8'h00, target, 8'h00}` encoding.
  - `RET`: pop, and PC ← the popped value.
  - Any other opcode, including undefined ones: PC ← PC+1.
- `iBranchTaken` is ignored for every opcode except `BEQ`/`BLE`.
- `CALL` with the stack full (count = STACK_DEPTH): no push, PC is held, go to `FAULT`.
- `RET` with the stack empty: PC is held, go to `FAULT`.
- `FAULT`:
  - `oFault`=1; PC and stack are frozen.
  - All inputs are ignored.
  - Exit only via `Reset`.
- `iStall`=1 in `RUN`: PC, stack and state are all unchanged. A stalled `CALL`/`RET` performs no push or pop.
- The stack is a register array plus a pointer. Push writes `mem[count]` and increments count; pop reads `mem[count-1]` and decrements count. `oReturnTop` = `mem[count-1]` when count>0.

## Timing
- Asynchronous reset values: PC=`RESET_ADDR`, `oAddress`=`RESET_ADDR`, count=0, `oReturnTop`=0, `oFault`=0, state=`RUN`.
- Stack contents after reset are don't-care but never observable.
- Reset asserted mid-`CALL` or mid-`RET` discards the operation completely; on the first edge after release, the instruction at `RESET_ADDR` executes.
- One instruction per cycle: `oAddress` updates on the rising edge after the instruction is presented. Redirect latency is 1 cycle, with no delay slot.
- `iInstruction` and `iBranchTaken` are sampled at the rising edge; both are combinational paths from `oAddress`.
- A `CALL` target that is itself a `CALL` nests normally, one push per cycle.
- Push and pop never occur in the same cycle.
- `oFault` rises on the edge that detects overflow or underflow.

## Structure
- Shared package/include holds:
  - opcode constants and field bit positions (`OP_MSB`/`OP_LSB`, A/B/C ranges);
  - state encodings `ST_RUN`, `ST_FAULT`.
- One sub-module: `return_stack`, a parameterized LIFO with push, pop, full, empty, top and count. The sequencer holds the PC, the state machine and the next-PC mux.

## Test plan
- Reset release with the ROM program loaded → `oAddress` = 0, then 100 on the next edge (`CALL` at 0). `oStackCount`=1 and `oReturnTop`=1.
- Run to `RET` at 117 → next `oAddress`=1 and count=0. After the three calls, fetch reaches 3.
- `BEQ` at 10 with `iBranchTaken`=1 → `oAddress`=15. With 0 → `oAddress`=11.
- Nine nested `CALL`s with STACK_DEPTH=8 → the ninth raises `oFault` and `oAddress` holds at the ninth `CALL`'s address. Later inputs have no effect until `Reset`.
- `RET` at count=0 → `oFault`=1 and PC unchanged.
- Sequential fetch from 255 → wraps to 0.
- `iStall`=1 for 3 cycles on a `CALL` → `oAddress` and count are unchanged. On release, exactly one push occurs.
- `Reset` pulsed asynchronously between edges → outputs clear immediately.
